// File: rtl/div_seq_r2.sv
// Iterative radix-2 restoring divider for unsigned mantissas: one quotient bit per
// clock through a single SW+1-bit subtractor, with valid/ready handshakes on both sides.
module div_seq_r2 #(
    parameter int DW = 50,
    parameter int SW = 24,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] opa,
    input  logic [SW-1:0] opb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quo,
    output logic [SW-1:0] rem,
    output logic          dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [SW:0]   pr;
    logic [DW-1:0] dq;
    logic [SW-1:0] d;
    logic [CW-1:0] cnt;

    logic [SW:0]   t;
    logic [SW:0]   diff;
    logic [SW:0]   pr_nx;
    logic          qbit;
    logic [DW-1:0] dq_nx;
    logic          last_iter;

    // pr never exceeds d, so its top bit is always zero and drops out of the shift.
    assign t         = (pr << 1) | (SW + 1)'(dq[DW-1]);
    assign diff      = t - {1'b0, d};
    assign qbit      = (t >= {1'b0, d});
    assign pr_nx     = qbit ? diff : t;
    assign dq_nx     = {dq[DW-2:0], qbit};
    assign last_iter = (cnt == CW'(1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = (opb == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result registers only change on accept (divide-by-zero) or on the last iteration,
    // so they stay frozen while a result waits in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr  <= '0;
            dq  <= '0;
            d   <= '0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d   <= opb;
                        dq  <= opa;
                        pr  <= '0;
                        cnt <= CW'(DW);
                        if (opb == '0) begin
                            quo <= '1;
                            rem <= SW'(opa);
                            dbz <= 1'b1;
                        end else begin
                            dbz <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    pr  <= pr_nx;
                    dq  <= dq_nx;
                    cnt <= cnt - CW'(1);
                    if (last_iter) begin
                        quo <= dq_nx;
                        rem <= pr_nx[SW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
